// File: rtl/sign_mag_sub_serial.sv
// Bit-serial sign-magnitude subtractor: diff = a - b, one magnitude bit per cycle, LSB first.
// Three-state FSM (idle/calc/done); diff and ovf are registered and held between results.
module sign_mag_sub_serial #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] diff_o,
  output logic         ovf_o
);

  localparam int unsigned M    = N - 1;
  localparam int unsigned CntW = $clog2(N);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 2);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic [M-1:0]    max_q, max_d, min_q, min_d, res_q, res_d;
  logic            sign_q, sign_d, same_q, same_d;
  logic [N-1:0]    diff_q, diff_d;
  logic            ovf_q, ovf_d;

  logic [M-1:0]    mag_a, mag_b, res_next;
  logic            a_gt_b;
  logic [1:0]      step;

  assign mag_a  = a_i[M-1:0];
  assign mag_b  = b_i[M-1:0];
  assign a_gt_b = mag_a > mag_b;

  // step[1] is carry-out (add) or borrow-out (subtract), step[0] the result bit
  always_comb begin
    if (same_q) begin
      step = {1'b0, max_q[0]} + {1'b0, min_q[0]} + {1'b0, carry_q};
    end else begin
      step = {1'b0, max_q[0]} - {1'b0, min_q[0]} - {1'b0, carry_q};
    end
  end

  assign res_next = {step[0], res_q[M-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    max_d   = max_q;
    min_d   = min_q;
    res_d   = res_q;
    sign_d  = sign_q;
    same_d  = same_q;
    diff_d  = diff_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StCalc;
          cnt_d   = '0;
          carry_d = 1'b0;
          res_d   = '0;
          max_d   = a_gt_b ? mag_a : mag_b;
          min_d   = a_gt_b ? mag_b : mag_a;
          sign_d  = a_gt_b ? a_i[M] : ~b_i[M];
          // b's sign is inverted, so equal effective signs means a and b signs differ
          same_d  = a_i[M] ^ b_i[M];
        end
      end
      StCalc: begin
        max_d   = max_q >> 1;
        min_d   = min_q >> 1;
        carry_d = step[1];
        res_d   = res_next;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          diff_d  = (res_next == '0) ? '0 : {sign_q, res_next};
          ovf_d   = same_q & step[1];
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      max_q   <= '0;
      min_q   <= '0;
      res_q   <= '0;
      sign_q  <= 1'b0;
      same_q  <= 1'b0;
      diff_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      max_q   <= max_d;
      min_q   <= min_d;
      res_q   <= res_d;
      sign_q  <= sign_d;
      same_q  <= same_d;
      diff_q  <= diff_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StDone);
  assign diff_o = diff_q;
  assign ovf_o  = ovf_q;

endmodule
